// File: rtl/cnt_mon_pkg.sv
// Shared types and constants for the counter step monitor.
package cnt_mon_pkg;

  localparam int CNT_W  = 4;
  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    INIT,
    TRACK,
    FAULT
  } mon_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] exp;
    logic [CNT_W-1:0] got;
  } ev_rec_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mon_event_fifo.sv
// Synchronous mismatch-record FIFO with sticky overflow flag; no fall-through,
// head data reads as zero while empty.
module mon_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_ovf,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    ovf_d    = clr_ovf ? 1'b0 : (ovf_q | (push & ~do_push));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign ovf  = ovf_q;

endmodule

// File: rtl/cnt_step_monitor.sv
// Step checker for the 4-bit loadable up/down counter: predicts each count,
// flags/counts mismatches and wraps. Event FIFO built only with CNT_STEP_MONITOR_FIFO_EN.
module cnt_step_monitor
  import cnt_mon_pkg::*;
#(
  parameter int W          = CNT_W,
  parameter int ERR_LIMIT  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              aset_in,
  input  logic              sclr_in,
  input  logic              load_in,
  input  logic              dir_in,
  input  logic [W-1:0]      din_in,
  input  logic [W-1:0]      cnt_in,
  input  logic              clear_in,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic              fault,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [W-1:0]      ev_exp,
  output logic [W-1:0]      ev_got,
  output logic              ovf
);

  localparam logic [STAT_W-1:0] ERR_LIM_C = STAT_W'(ERR_LIMIT);

  mon_state_e        state_q, state_d;
  logic [W-1:0]      prev_cnt_q, prev_cnt_d;
  logic [W-1:0]      din_q, din_d;
  logic              sclr_q, sclr_d, load_q, load_d, dir_q, dir_d;
  logic              err_pulse_q, err_pulse_d;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
  logic [STAT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [W-1:0]      expected;
  logic              cmp_en, mismatch, wrap_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    expected = sclr_q ? '0 :
               load_q ? din_q :
               dir_q  ? prev_cnt_q + 1'b1 : prev_cnt_q - 1'b1;
    if (aset_in) expected = '1;

    cmp_en   = (state_q != INIT) && !aset_in;
    mismatch = cmp_en && (cnt_in != expected);
    wrap_hit = cmp_en && !mismatch && !sclr_q && !load_q &&
               (dir_q ? (prev_cnt_q == '1 && cnt_in == '0)
                      : (prev_cnt_q == '0 && cnt_in == '1));

    // A set counter resumes counting from all-ones on the next cycle.
    prev_cnt_d  = aset_in ? '1 : cnt_in;
    sclr_d      = sclr_in;
    load_d      = load_in;
    dir_d       = dir_in;
    din_d       = din_in;
    err_pulse_d = mismatch;
    err_cnt_d   = clear_in ? '0 : (mismatch ? sat_inc(err_cnt_q) : err_cnt_q);
    wrap_cnt_d  = clear_in ? '0 : (wrap_hit ? wrap_cnt_q + 1'b1 : wrap_cnt_q);

    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = TRACK;
      TRACK:   if (err_cnt_d >= ERR_LIM_C) state_d = FAULT;
      FAULT:   if (clear_in) state_d = TRACK;
      default: state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= INIT;
      prev_cnt_q  <= '0;
      din_q       <= '0;
      sclr_q      <= 1'b0;
      load_q      <= 1'b0;
      dir_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_cnt_q  <= prev_cnt_d;
      din_q       <= din_d;
      sclr_q      <= sclr_d;
      load_q      <= load_d;
      dir_q       <= dir_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign fault     = (state_q == FAULT);

`ifdef CNT_STEP_MONITOR_FIFO_EN
  logic [2*W-1:0] rec_head;
  logic           fifo_empty;
  logic           unused_fifo_full;

  // A record pushed alongside a clear is kept; clear only resets the sticky ovf.
  mon_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (2*W)
  ) u_fifo (
    .clk     (clk),
    .rst     (aclr),
    .push    (mismatch),
    .pop     (ev_ready),
    .clr_ovf (clear_in),
    .din     ({expected, cnt_in}),
    .dout    (rec_head),
    .full    (unused_fifo_full),
    .empty   (fifo_empty),
    .ovf     (ovf)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_exp   = rec_head[2*W-1:W];
  assign ev_got   = rec_head[W-1:0];
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic unused_ev_ready;

  assign unused_ev_ready = ev_ready;
  assign ev_valid        = 1'b0;
  assign ev_exp          = '0;
  assign ev_got          = '0;
  assign ovf             = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_step_monitor.sv
// Scoreboard bench for cnt_step_monitor: a queue-based reference model of the
// counter-step rules predicts every post-edge output; a monitor pops and compares.
module tb_cnt_step_monitor;
  import cnt_mon_pkg::*;

  localparam int W         = 4;
  localparam int ERR_LIMIT = 8;
  localparam int DEPTH     = 4;
  localparam int MAXV      = (1 << W) - 1;
`ifdef CNT_STEP_MONITOR_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         aclr, aset_in, sclr_in, load_in, dir_in, clear_in, ev_ready;
  logic [W-1:0] din_in, cnt_in;
  logic         err_pulse, fault, ev_valid, ovf;
  logic [7:0]   err_cnt, wrap_cnt;
  logic [W-1:0] ev_exp, ev_got;

  cnt_step_monitor #(.W(W), .ERR_LIMIT(ERR_LIMIT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .aclr(aclr), .aset_in(aset_in), .sclr_in(sclr_in), .load_in(load_in),
    .dir_in(dir_in), .din_in(din_in), .cnt_in(cnt_in), .clear_in(clear_in),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .fault(fault),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_exp(ev_exp), .ev_got(ev_got), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit err_pulse;
    int err_cnt;
    int wrap_cnt;
    bit fault;
    bit ovf;
    bit ev_valid;
    int ev_exp;
    int ev_got;
  } exp_t;

  exp_t    exp_q[$];
  ev_rec_t m_fifo[$];

  // Reference model state: what the monitor "knows" about the counter.
  bit m_hist, m_sclr, m_load, m_dir, m_fault, m_ovf;
  int m_prev, m_din, m_err, m_wrap;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int m_predict();
    if (m_sclr) return 0;
    if (m_load) return m_din;
    if (m_dir)  return (m_prev + 1) % (MAXV + 1);
    return (m_prev + MAXV) % (MAXV + 1);
  endfunction

  task automatic model_reset();
    m_hist = 0; m_sclr = 0; m_load = 0; m_dir = 0; m_fault = 0; m_ovf = 0;
    m_prev = 0; m_din = 0; m_err = 0; m_wrap = 0;
    m_fifo.delete();
  endtask

  // Drive one cycle of inputs, advance the model, queue the post-edge expectation.
  task automatic step(input bit aset, input bit sclr, input bit load, input bit dir,
                      input int din, input int cnt, input bit clr, input bit rdy);
    exp_t e;
    int   ev;
    bit   cmp, mis, wrp, was_full, popd;
    aset_in = aset; sclr_in = sclr; load_in = load; dir_in = dir;
    din_in = W'(din); cnt_in = W'(cnt); clear_in = clr; ev_ready = rdy;

    cmp = m_hist && !aset;
    ev  = aset ? MAXV : m_predict();
    mis = cmp && (cnt != ev);
    wrp = cmp && !mis && !m_sclr && !m_load &&
          ((m_dir && m_prev == MAXV && cnt == 0) || (!m_dir && m_prev == 0 && cnt == MAXV));

    if (FIFO_EN) begin
      was_full = (m_fifo.size() == DEPTH);
      popd     = rdy && (m_fifo.size() > 0);
      if (popd) void'(m_fifo.pop_front());
      if (mis) begin
        if (!was_full || popd) m_fifo.push_back('{exp: W'(ev), got: W'(cnt)});
        else m_ovf = 1;
      end
      if (clr) m_ovf = 0;
    end

    if (clr) m_err = 0;
    else if (mis) m_err = (m_err >= 255) ? 255 : m_err + 1;
    if (clr) m_wrap = 0;
    else if (wrp) m_wrap = (m_wrap + 1) % 256;

    if (!m_hist) m_fault = 0;
    else if (m_fault) begin
      if (clr) m_fault = 0;
    end else if (m_err >= ERR_LIMIT) m_fault = 1;

    m_prev = aset ? MAXV : cnt;
    m_sclr = sclr; m_load = load; m_dir = dir; m_din = din; m_hist = 1;

    e.err_pulse = mis;
    e.err_cnt   = m_err;
    e.wrap_cnt  = m_wrap;
    e.fault     = m_fault;
    e.ovf       = m_ovf;
    e.ev_valid  = (m_fifo.size() > 0);
    e.ev_exp    = e.ev_valid ? int'(m_fifo[0].exp) : 0;
    e.ev_got    = e.ev_valid ? int'(m_fifo[0].got) : 0;

    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_err_pulse"}, int'(err_pulse), 0);
    check({tag, "_err_cnt"},   int'(err_cnt),   0);
    check({tag, "_wrap_cnt"},  int'(wrap_cnt),  0);
    check({tag, "_fault"},     int'(fault),     0);
    check({tag, "_ev_valid"},  int'(ev_valid),  0);
    check({tag, "_ev_exp"},    int'(ev_exp),    0);
    check({tag, "_ev_got"},    int'(ev_got),    0);
    check({tag, "_ovf"},       int'(ovf),       0);
  endtask

  // Monitor: compares DUT outputs against the oldest expectation, mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("err_pulse", int'(err_pulse), int'(e.err_pulse));
        check("err_cnt",   int'(err_cnt),   e.err_cnt);
        check("wrap_cnt",  int'(wrap_cnt),  e.wrap_cnt);
        check("fault",     int'(fault),     int'(e.fault));
        check("ovf",       int'(ovf),       int'(e.ovf));
        check("ev_valid",  int'(ev_valid),  int'(e.ev_valid));
        if (e.ev_valid || !FIFO_EN) begin
          check("ev_exp", int'(ev_exp), e.ev_exp);
          check("ev_got", int'(ev_got), e.ev_got);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c;
    aclr = 1'b1; aset_in = 0; sclr_in = 0; load_in = 0; dir_in = 0;
    din_in = '0; cnt_in = '0; clear_in = 0; ev_ready = 0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    aclr = 1'b0;

    // Up-count from 0 through one wrap.
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, m_predict(), 0, 0);

    // Load 9 at count 3, count down, then present 5 where 7 is due.
    step(0, 0, 1, 1, 3, m_predict(), 0, 0);
    step(0, 0, 1, 0, 9, 3, 0, 0);
    step(0, 0, 0, 0, 0, 9, 0, 0);
    step(0, 0, 0, 0, 0, 8, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, m_predict(), 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, m_predict(), 0, 1);

    // sclr beats load: 0 passes, 6 is flagged.
    step(0, 1, 1, 1, 6, m_predict(), 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 1, 6, m_predict(), 0, 0);
    step(0, 0, 0, 1, 0, 6, 0, 0);
    step(0, 0, 0, 1, 0, m_predict(), 0, 1);

    // aset pulse mid-count, then 0 counts up as a wrap.
    step(0, 0, 0, 1, 0, m_predict(), 0, 1);
    step(1, 0, 0, 1, 0, MAXV, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, m_predict(), 0, 1);

    // Clear, then 8 back-to-back mismatches with the FIFO stalled.
    step(0, 0, 0, 1, 0, m_predict(), 1, 1);
    step(0, 0, 0, 1, 0, m_predict(), 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, m_predict() ^ 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, m_predict(), 0, 1);
    step(0, 0, 0, 1, 0, m_predict(), 1, 1);
    step(0, 0, 0, 1, 0, m_predict(), 0, 1);

    // Randomised traffic with occasional faults, sets, clears and stalls.
    for (int i = 0; i < 400; i++) begin
      bit a, s, l, d, cl, r;
      int dn;
      a  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 9) == 0);
      l  = ($urandom_range(0, 5) == 0);
      d  = 1'($urandom_range(0, 1));
      dn = $urandom_range(0, MAXV);
      cl = ($urandom_range(0, 29) == 0);
      r  = ($urandom_range(0, 2) != 0);
      c  = a ? MAXV : m_predict();
      if ($urandom_range(0, 7) == 0) c = $urandom_range(0, MAXV);
      step(a, s, l, d, dn, c, cl, r);
    end

    // Asynchronous reset between edges with a pending record.
    step(0, 0, 0, 1, 0, m_predict(), 1, 0);
    step(0, 0, 0, 1, 0, m_predict() ^ 2, 0, 0);
    @(negedge clk);
    #1;
    aclr = 1'b1;
    #1;
    check_all_zero("aclr");
    model_reset();
    #2;
    aclr = 1'b0;
    step(0, 0, 0, 1, 0, 7, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, m_predict(), 0, 1);
    step(0, 0, 0, 1, 0, m_predict() ^ 4, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, m_predict(), 0, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
